// File: rtl/mdr_sequencer.sv
// mdr_sequencer: multicycle controller for MDR multiply / divide / square-root commands.
// Drives an external shared add/sub/shift ALU one iteration per clock, then reports via done.
module mdr_sequencer #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = $clog2(DW) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [DW-1:0]   operand_a,
  input  logic [DW-1:0]   operand_b,
  output logic            ready,
  output logic            done,
  output logic [DW-1:0]   result_hi,
  output logic [DW-1:0]   result_lo,
  output logic            error,
  output logic [2:0]      alu_select,
  output logic [DW-1:0]   alu_value_x,
  output logic [2*DW-1:0] alu_value_d,
  output logic [DW-1:0]   alu_operator_a,
  output logic [DW-1:0]   alu_operator_b,
  input  logic [DW-1:0]   alu_add,
  input  logic [DW-1:0]   alu_sub,
  input  logic [DW-1:0]   alu_shift
);

  localparam logic [2:0] OpNone      = 3'd0;
  localparam logic [2:0] OpMult      = 3'd1;
  localparam logic [2:0] OpDiv       = 3'd2;
  localparam logic [2:0] OpSqrt      = 3'd3;
  localparam logic [2:0] OpSqrtFinal = 3'd4;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StFinal, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [DW-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [DW-1:0]   acc_q, acc_d;  // A for MULT, R for DIV/SQRT
  logic [DW-1:0]   q_q, q_d;
  logic            q1_q, q1_d;
  logic [DW-1:0]   x_q, x_d;
  logic [DW-1:0]   b_q, b_d;
  logic [2*DW-1:0] d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic            err_q, err_d;

  logic [DW-1:0]   acc_next, div_rs;
  logic            div_take, div_zero, load_err;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    acc_d          = acc_q;
    q_d            = q_q;
    q1_d           = q1_q;
    x_d            = x_q;
    b_d            = b_q;
    d_d            = d_q;
    cnt_d          = cnt_q;
    res_hi_d       = res_hi_q;
    res_lo_d       = res_lo_q;
    err_d          = err_q;
    alu_select     = OpNone;
    alu_operator_a = '0;
    alu_operator_b = '0;
    acc_next       = acc_q;
    // Restoring-divide step: the bit leaving R forces a subtract, and the n-bit wrap is exact.
    div_rs         = {acc_q[DW-2:0], q_q[DW-1]};
    div_take       = acc_q[DW-1] | (div_rs >= x_q);
    div_zero       = (op_q == OpDiv) && (opb_q == '0);
    load_err       = div_zero || ((op_q == OpMult) && (opa_q == {1'b1, {(DW-1){1'b0}}})) ||
                     !(op_q inside {OpMult, OpDiv, OpSqrt});

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          opa_d   = operand_a;
          opb_d   = operand_b;
          state_d = StLoad;
        end
      end
      StLoad: begin
        acc_d = '0;
        q1_d  = 1'b0;
        b_d   = '0;
        x_d   = (op_q == OpDiv) ? opb_q : opa_q;
        q_d   = (op_q == OpDiv) ? opa_q : opb_q;
        if (op_q == OpSqrt) begin
          d_d   = {opa_q, {DW{1'b0}}};
          cnt_d = CW'(DW / 2);
        end else begin
          d_d   = '0;
          cnt_d = CW'(DW);
        end
        if (load_err) begin
          err_d    = 1'b1;
          res_hi_d = div_zero ? opa_q : '0;
          res_lo_d = div_zero ? '1 : '0;
          state_d  = StDone;
        end else begin
          err_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        alu_select = op_q;
        cnt_d      = cnt_q - CW'(1);
        case (op_q)
          OpMult: begin
            alu_operator_a = acc_q;
            alu_operator_b = x_q;
            case ({q_q[0], q1_q})
              2'b10:   acc_next = alu_sub;
              2'b01:   acc_next = alu_add;
              default: acc_next = alu_shift;
            endcase
            acc_d = {acc_next[DW-1], acc_next[DW-1:1]};
            q_d   = {acc_next[0], q_q[DW-1:1]};
            q1_d  = q_q[0];
          end
          OpDiv: begin
            alu_operator_a = div_rs;
            alu_operator_b = x_q;
            acc_d          = div_take ? alu_sub : div_rs;
            q_d            = {q_q[DW-2:0], div_take};
          end
          default: begin
            // Non-restoring root: operand b ends in 01 (subtract) or 11 (add) by R's sign.
            alu_operator_a = {acc_q[DW-3:0], d_q[2*DW-1 -: 2]};
            alu_operator_b = {b_q[DW-3:0], acc_q[DW-1], 1'b1};
            acc_d          = acc_q[DW-1] ? alu_add : alu_sub;
            b_d            = {b_q[DW-2:0], ~acc_d[DW-1]};
            d_d            = d_q << 2;
          end
        endcase
        if (cnt_q == CW'(1)) begin
          if (op_q == OpSqrt) begin
            state_d = StFinal;
          end else begin
            res_hi_d = acc_d;
            res_lo_d = q_d;
            state_d  = StDone;
          end
        end
      end
      StFinal: begin
        alu_select     = OpSqrtFinal;
        alu_operator_a = acc_q;
        alu_operator_b = {b_q[DW-2:0], 1'b1};
        if (acc_q[DW-1]) acc_d = alu_add;
        res_hi_d = acc_d;
        res_lo_d = b_q;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpNone;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      x_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      x_q      <= x_d;
      b_q      <= b_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      err_q    <= err_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign done        = (state_q == StDone);
  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign error       = err_q;
  assign alu_value_x = x_q;
  assign alu_value_d = d_q;

endmodule

// File: tb/tb_mdr_sequencer.sv
// Bench for mdr_sequencer: arithmetic ALU model, queue scoreboard filled by the driver and
// drained by a done-triggered monitor, directed corner cases plus randomized commands.
module tb_mdr_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = $clog2(DW) + 1;
  localparam logic [2:0] OpNone      = 3'd0;
  localparam logic [2:0] OpMult      = 3'd1;
  localparam logic [2:0] OpDiv       = 3'd2;
  localparam logic [2:0] OpSqrt      = 3'd3;
  localparam logic [2:0] OpSqrtFinal = 3'd4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      op = '0;
  logic [DW-1:0]   operand_a = '0, operand_b = '0;
  logic            ready, done, error;
  logic [DW-1:0]   result_hi, result_lo;
  logic [2:0]      alu_select;
  logic [DW-1:0]   alu_value_x;
  logic [2*DW-1:0] alu_value_d;
  logic [DW-1:0]   alu_operator_a, alu_operator_b, alu_add, alu_sub, alu_shift;

  mdr_sequencer #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .ready(ready), .done(done), .result_hi(result_hi), .result_lo(result_lo), .error(error),
    .alu_select(alu_select), .alu_value_x(alu_value_x), .alu_value_d(alu_value_d),
    .alu_operator_a(alu_operator_a), .alu_operator_b(alu_operator_b),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_shift(alu_shift)
  );

  always #5 clk = ~clk;

  // External ALU: plain add / subtract / pass-through.
  assign alu_add   = alu_operator_a + alu_operator_b;
  assign alu_sub   = alu_operator_a - alu_operator_b;
  assign alu_shift = alu_operator_a;

  typedef struct {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          err;
    int            lat;
    int            start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic hold_start = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  function automatic exp_t model(input logic [2:0] o, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b);
    exp_t            e;
    logic [2*DW-1:0] p;
    longint          r;
    e.hi = '0; e.lo = '0; e.err = 1'b0; e.lat = 2; e.start_cyc = 0;
    if (o == OpMult) begin
      if (a == {1'b1, {(DW-1){1'b0}}}) begin
        e.err = 1'b1;
      end else begin
        p    = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
        e.hi = p[2*DW-1:DW];
        e.lo = p[DW-1:0];
        e.lat = DW + 2;
      end
    end else if (o == OpDiv) begin
      if (b == '0) begin
        e.err = 1'b1; e.hi = a; e.lo = '1;
      end else begin
        e.lo = a / b; e.hi = a % b; e.lat = DW + 2;
      end
    end else if (o == OpSqrt) begin
      r = 0;
      while ((r + 1) * (r + 1) <= longint'(a)) r++;
      e.lo  = DW'(r);
      e.hi  = DW'(longint'(a) - r * r);
      e.lat = DW / 2 + 3;
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: reset-state checks after any reset edge, scoreboard compare on done.
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      exp_q.delete();
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_result_hi", result_hi, 0);
      check("rst_result_lo", result_lo, 0);
      check("rst_alu_select", alu_select, OpNone);
    end else if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, required no pending command (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result_hi", result_hi, e.hi);
        check("result_lo", result_lo, e.lo);
        check("error", error, e.err);
        check("latency", cyc - e.start_cyc, e.lat);
        check("ready_at_done", ready, 0);
      end
    end else if (exp_q.size() > 0 && (cyc - exp_q[0].start_cyc) > exp_q[0].lat) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, required %0d",
               cyc - exp_q[0].start_cyc, exp_q[0].lat);
      void'(exp_q.pop_front());
    end
  end

  task automatic issue(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (!ready && guard < 200) begin
      start     = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
      op        = 3'($urandom_range(0, 7));
      operand_a = DW'($urandom);
      operand_b = DW'($urandom);
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      $display("FAIL ready_timeout: got ready=0 for %0d cycles, required 1", guard);
      $fatal(1);
    end
    e           = model(o, a, b);
    e.start_cyc = cyc;
    start       = 1'b1;
    op          = o;
    operand_a   = a;
    operand_b   = b;
    exp_q.push_back(e);
  endtask

  task automatic random_cmd();
    int            sel;
    logic [2:0]    o;
    logic [DW-1:0] a, b;
    sel = $urandom_range(0, 15);
    a   = DW'($urandom);
    b   = DW'($urandom);
    if (sel <= 4)       o = OpMult;
    else if (sel <= 9)  o = OpDiv;
    else if (sel <= 13) o = OpSqrt;
    else if (sel == 14) begin
      o = 3'($urandom_range(4, 8) % 8);
    end else begin
      o = ($urandom_range(0, 1) == 1) ? OpDiv : OpMult;
      if (o == OpDiv) b = '0;
      else            a = {1'b1, {(DW-1){1'b0}}};
    end
    issue(o, a, b);
  endtask

  initial begin
    int k;
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    issue(OpMult, 16'd7, 16'hFFFD);
    issue(OpDiv, 16'd1000, 16'd7);
    issue(OpDiv, 16'hFFFF, 16'h8001);
    issue(OpSqrt, 16'd144, 16'd0);
    issue(OpSqrt, 16'hFFFF, 16'h1234);
    issue(OpDiv, 16'd5, 16'd0);
    issue(OpMult, 16'h8000, 16'd5);
    issue(OpMult, 16'h7FFF, 16'h8000);
    issue(OpNone, 16'd1, 16'd2);
    issue(OpSqrtFinal, 16'd9, 16'd3);
    issue(3'd7, 16'd3, 16'd4);

    // Reset during the fifth RUN cycle discards the command.
    issue(OpMult, 16'd100, 16'd200);
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(OpMult, 16'd3, 16'd4);

    hold_start = 1'b1;
    repeat (10) random_cmd();
    hold_start = 1'b0;
    repeat (120) random_cmd();

    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: got %0d pending commands, required 0", exp_q.size());
      $fatal(1);
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
